logic_op_scheduler: RTL and testbench

- Shares one registered bitwise logic unit (AND/OR/XOR/NOT) between NUM_REQ requesters.
- Each requester presents an opcode and two operands over a valid/ready handshake.
- The block arbitrates round-robin, executes one operation, and returns the result tagged with the requester id over a valid/ready response channel.
- It is the sequencing front end for the team's bitwise operand datapath: x/y operands producing z.

---
 rtl/logic_op_scheduler.sv | 137 +++++++++++++
 tb/tb_logic_op_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler sharing one registered bitwise logic unit (AND/OR/XOR/NOT) among NUM_REQ requesters.
// Optional trace (response print + ops_done counter) enabled by defining LOGIC_OP_SCHEDULER_TRACE_EN.
module logic_op_scheduler #(
  parameter int WIDTH   = 1,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [1:0]        r_op;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [ID_W-1:0]   r_id;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [WIDTH-1:0]  r_rsp_data;
  logic              r_busy;

  logic              w_found;
  logic [ID_W-1:0]   w_grant;
  int                w_idx;
  logic [NUM_REQ-1:0] w_onehot;

  function automatic logic [WIDTH-1:0] f_logic(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   f_logic = a & b;
      2'b01:   f_logic = a | b;
      2'b10:   f_logic = a ^ b;
      default: f_logic = ~a;
    endcase
  endfunction

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = ID_W'(w_idx);
      end
    end
  end

  // rst_n gating keeps ready low while reset is held even if requests are pending.
  always_comb begin
    w_onehot = '0;
    if (r_state == S_IDLE && rst_n && w_found)
      w_onehot[w_grant] = 1'b1;
  end

  assign req_ready = w_onehot;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op    <= req_op[2*w_grant +: 2];
            r_a     <= req_a[w_grant*WIDTH +: WIDTH];
            r_b     <= req_b[w_grant*WIDTH +: WIDTH];
            r_id    <= w_grant;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= f_logic(r_op, r_a, r_b);
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= (r_id == ID_W'(NUM_REQ-1)) ? '0 : r_id + 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOGIC_OP_SCHEDULER_TRACE_EN
  logic [31:0] ops_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_done <= '0;
    end else if (r_rsp_valid && rsp_ready) begin
      ops_done <= ops_done + 32'd1;
      $display("id=%0d op=%b x=%b y=%b z=%b", r_rsp_id, r_op, r_a, r_b, r_rsp_data);
    end
  end
`endif

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Scoreboard bench for logic_op_scheduler (WIDTH=1, NUM_REQ=2).
module tb_logic_op_scheduler;
  localparam int WIDTH   = 1;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     busy;

  logic_op_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   acc_cyc[$];
  int   n_tests;
  int   n_fails;
  int   cyc;
  bit   accepted;

  function automatic logic model(input logic [1:0] op, input logic a, input logic b);
    case (op)
      2'b00:   model = a & b;
      2'b01:   model = a | b;
      2'b10:   model = a ^ b;
      default: model = ~a;
    endcase
  endfunction

  // One clock: sample handshakes at negedge, then return #1 after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id   = ID_W'(i);
        e.data = model(req_op[2*i +: 2], req_a[i], req_b[i]);
        sb.push_back(e);
        grants.push_back(i);
        acc_cyc.push_back(cyc);
        accepted = 1'b1;
      end
    end
    if (rsp_valid && rsp_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fails++;
        $display("FAIL sb_unexpected: got id=%0d data=%b, expected no response", rsp_id, rsp_data);
      end else begin
        e = sb.pop_front();
        if (rsp_id !== e.id || rsp_data !== e.data) begin
          n_fails++;
          $display("FAIL sb_result: got id=%0d data=%b, expected id=%0d data=%b",
                   rsp_id, rsp_data, e.id, e.data);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic a, input logic b);
    req_op[2*i +: 2] = op;
    req_a[i]         = a;
    req_b[i]         = b;
    req_valid[i]     = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (accepted) break;
    end
    n_tests++;
    if (!accepted) begin
      n_fails++;
      $display("FAIL issue_timeout: requester %0d got no grant, expected accept within 20 cycles", i);
    end
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30; k++) begin
      if (!busy && sb.size() == 0) break;
      tick();
    end
    n_tests++;
    if (busy || sb.size() != 0) begin
      n_fails++;
      $display("FAIL idle_timeout: busy=%b pending=%0d, expected busy=0 pending=0", busy, sb.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_op    = '0;
    req_a     = '1;
    req_b     = '1;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
      n_fails++;
      $display("FAIL reset_outputs: ready=%b vld=%b id=%0d data=%b busy=%b, expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_data, busy);
    end
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_xor();
    req_op[1:0]  = 2'b10;
    req_a[0]     = 1'b0;
    req_b[0]     = 1'b1;
    rsp_ready    = 1'b1;
    req_valid    = 2'b01;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fails++;
      $display("FAIL xor_ready: got %b, expected 01", req_ready);
    end
    tick();
    req_valid = '0;
    n_tests++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
      n_fails++;
      $display("FAIL xor_exec: busy=%b vld=%b ready=%b, expected 1 0 00", busy, rsp_valid, req_ready);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 1'b1) begin
      n_fails++;
      $display("FAIL xor_resp: vld=%b id=%0d data=%b, expected 1 0 1", rsp_valid, rsp_id, rsp_data);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL xor_done: busy=%b vld=%b, expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_or_not();
    issue(1, 2'b01, 1'b0, 1'b0);
    wait_idle();
    issue(1, 2'b11, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic test_all_ops();
    for (int op = 0; op < 4; op++)
      for (int ab = 0; ab < 4; ab++) begin
        issue(ab % 2, 2'(op), ab[1], ab[0]);
        wait_idle();
      end
  endtask

  task automatic test_contention();
    do_reset();
    grants.delete();
    acc_cyc.delete();
    req_op    = {2'b10, 2'b00};
    req_a     = 2'b11;
    req_b     = 2'b11;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 40; k++) begin
      if (grants.size() >= 4) break;
      tick();
    end
    req_valid = '0;
    wait_idle();
    n_tests++;
    if (grants.size() != 4) begin
      n_fails++;
      $display("FAIL contention_count: got %0d grants, expected 4", grants.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (grants[k] != k % 2) begin
          n_fails++;
          $display("FAIL contention_order[%0d]: got %0d, expected %0d", k, grants[k], k % 2);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (acc_cyc[k+1] - acc_cyc[k] != 3) begin
          n_fails++;
          $display("FAIL contention_spacing[%0d]: got %0d, expected 3", k, acc_cyc[k+1] - acc_cyc[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [ID_W-1:0] id0;
    logic            d0;
    rsp_ready = 1'b0;
    issue(1, 2'b10, 1'b1, 1'b0);
    req_op[1:0] = 2'b01;
    req_a[0]    = 1'b0;
    req_b[0]    = 1'b1;
    req_valid   = 2'b01;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid) break;
      tick();
    end
    id0 = rsp_id;
    d0  = rsp_data;
    n_tests++;
    if (rsp_valid !== 1'b1 || id0 !== 1'b1 || d0 !== 1'b1) begin
      n_fails++;
      $display("FAIL bp_first: vld=%b id=%0d data=%b, expected 1 1 1", rsp_valid, id0, d0);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_data !== d0 || req_ready !== 2'b00) begin
        n_fails++;
        $display("FAIL bp_hold[%0d]: vld=%b id=%0d data=%b ready=%b, expected 1 %0d %b 00",
                 k, rsp_valid, rsp_id, rsp_data, req_ready, id0, d0);
      end
    end
    rsp_ready = 1'b1;
    tick();
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b01) begin
      n_fails++;
      $display("FAIL bp_release: vld=%b busy=%b ready=%b, expected 0 0 01", rsp_valid, busy, req_ready);
    end
    tick();
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_reset_mid_op();
    rsp_ready = 1'b1;
    issue(0, 2'b00, 1'b1, 1'b1);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fails++;
      $display("FAIL midrst_exec: busy=%b, expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
      n_fails++;
      $display("FAIL midrst_outputs: ready=%b vld=%b id=%0d data=%b busy=%b, expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_data, busy);
    end
    sb.delete();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_tests++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        n_fails++;
        $display("FAIL midrst_quiet[%0d]: vld=%b busy=%b, expected 0 0", k, rsp_valid, busy);
      end
    end
  endtask

  task automatic test_operand_change();
    rsp_ready = 1'b1;
    issue(0, 2'b11, 1'b1, 1'b0);
    req_a[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid) break;
      tick();
    end
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 1'b0) begin
      n_fails++;
      $display("FAIL opchange: vld=%b data=%b, expected 1 0", rsp_valid, rsp_data);
    end
    wait_idle();
  endtask

  initial begin
    n_tests   = 0;
    n_fails   = 0;
    cyc       = 0;
    accepted  = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_xor();
    test_or_not();
    test_all_ops();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_operand_change();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
